// File: rtl/stack_seq_pkg.sv
// Purpose: shared op codes, FSM states and memory-select encodings for the stack sequencer.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: n/a.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } op_code_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PUSH    = 4'd1,
    S_POP     = 4'd2,
    S_CALL_HI = 4'd3,
    S_CALL_LO = 4'd4,
    S_RET_LO  = 4'd5,
    S_RET_HI  = 4'd6,
    S_RET_JMP = 4'd7,
    S_INT_FL  = 4'd8,
    S_INT_HI  = 4'd9,
    S_INT_LO  = 4'd10,
    S_INT_JMP = 4'd11,
    S_RTI_LO  = 4'd12,
    S_RTI_HI  = 4'd13,
    S_RTI_FL  = 4'd14
  } state_e;

  localparam logic [1:0] MEM_SRC_FLAGS = 2'b00;
  localparam logic [1:0] MEM_SRC_PC_HI = 2'b01;
  localparam logic [1:0] MEM_SRC_PC_LO = 2'b10;
  localparam logic [1:0] MEM_SRC_REG   = 2'b11;

  localparam logic [1:0] MEM_ADDR_STD = 2'b00;
  localparam logic [1:0] MEM_ADDR_LDD = 2'b01;
  localparam logic [1:0] MEM_ADDR_SP  = 2'b10;

  // Last micro-op of each sequence; a new op may be accepted here.
  function automatic logic is_final(input state_e s);
    return (s == S_PUSH) || (s == S_POP) || (s == S_CALL_LO) ||
           (s == S_RET_JMP) || (s == S_INT_JMP) || (s == S_RTI_FL);
  endfunction

  // Entry state of each op; NONE and the reserved code map to IDLE.
  function automatic state_e first_state(input op_code_e op);
    state_e s;
    case (op)
      OP_PUSH: s = S_PUSH;
      OP_POP:  s = S_POP;
      OP_CALL: s = S_CALL_HI;
      OP_RET:  s = S_RET_LO;
      OP_INT:  s = S_INT_FL;
      OP_RTI:  s = S_RTI_LO;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stack_op_sequencer.sv
// Purpose: expands stack-class ops and interrupts into one-word-per-cycle memory micro-ops.
// Latency: first micro-op in the cycle after acceptance; ops chain back-to-back from final states.
// Backpressure: op_ready only in IDLE/final states; stall freezes upstream during multi-cycle sequences.
module stack_op_sequencer
  import stack_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic        int_req,
  input  logic [15:0] mem_data,
  output logic        op_ready,
  output logic        stall,
  output logic        memory_read,
  output logic        memory_write,
  output logic        memory_push,
  output logic        memory_pop,
  output logic [1:0]  memory_write_src_select,
  output logic [1:0]  memory_address_select,
  output logic        interrupt,
  output logic        pc_choose_memory,
  output logic        flags_restore_valid,
  output logic [2:0]  flags_restore
);

  state_e   state_q, state_d;
  logic     int_pending_q, int_pending_d;
  op_code_e op;
  logic     accept;
  logic     take_int;
  logic     long_op;
  logic     is_push, is_pop;

  // Only the low three bits carry flags; the rest of the word is ignored.
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data[15:3];

  assign op = op_code_e'(op_code);

  // Moore output decode, acceptance/interrupt arbitration and next-state selection.
  always_comb begin
    is_push                 = 1'b0;
    is_pop                  = 1'b0;
    memory_write_src_select = MEM_SRC_FLAGS;
    interrupt               = 1'b0;
    pc_choose_memory        = 1'b0;
    flags_restore_valid     = 1'b0;
    flags_restore           = 3'b000;

    case (state_q)
      S_PUSH:    begin is_push = 1'b1; memory_write_src_select = MEM_SRC_REG;   end
      S_CALL_HI: begin is_push = 1'b1; memory_write_src_select = MEM_SRC_PC_HI; end
      S_CALL_LO: begin is_push = 1'b1; memory_write_src_select = MEM_SRC_PC_LO; end
      S_INT_FL:  begin is_push = 1'b1; memory_write_src_select = MEM_SRC_FLAGS; end
      S_INT_HI:  begin is_push = 1'b1; memory_write_src_select = MEM_SRC_PC_HI; end
      S_INT_LO:  begin is_push = 1'b1; memory_write_src_select = MEM_SRC_PC_LO; end
      S_POP, S_RET_LO, S_RET_HI, S_RTI_LO, S_RTI_HI: is_pop = 1'b1;
      S_RET_JMP: pc_choose_memory = 1'b1;
      S_INT_JMP: interrupt = 1'b1;
      S_RTI_FL: begin
        // The popped-PC shift register still holds {hi, lo} during this pop.
        is_pop              = 1'b1;
        pc_choose_memory    = 1'b1;
        flags_restore_valid = 1'b1;
        flags_restore       = mem_data[2:0];
      end
      default: ;
    endcase

    memory_push           = is_push;
    memory_write          = is_push;
    memory_pop            = is_pop;
    memory_read           = is_pop;
    memory_address_select = (is_push || is_pop) ? MEM_ADDR_SP : MEM_ADDR_STD;

    op_ready = (state_q == S_IDLE) || is_final(state_q);
    take_int = op_ready && int_pending_q;
    accept   = op_ready && op_valid && !int_pending_q &&
               (op != OP_NONE) && (op != OP_RSVD);
    long_op  = (op == OP_CALL) || (op == OP_RET) || (op == OP_INT) || (op == OP_RTI);
    stall    = !op_ready || take_int || (accept && long_op);

    // A pending interrupt is consumed on entry to its push sequence only.
    int_pending_d = int_pending_q;
    if (take_int) begin
      int_pending_d = 1'b0;
    end else if (int_req) begin
      int_pending_d = 1'b1;
    end

    state_d = S_IDLE;
    if (take_int) begin
      state_d = S_INT_FL;
    end else if (accept) begin
      state_d = first_state(op);
    end else begin
      case (state_q)
        S_CALL_HI: state_d = S_CALL_LO;
        S_RET_LO:  state_d = S_RET_HI;
        S_RET_HI:  state_d = S_RET_JMP;
        S_INT_FL:  state_d = S_INT_HI;
        S_INT_HI:  state_d = S_INT_LO;
        S_INT_LO:  state_d = S_INT_JMP;
        S_RTI_LO:  state_d = S_RTI_HI;
        S_RTI_HI:  state_d = S_RTI_FL;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // State and interrupt latch; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Purpose: directed table of per-cycle inputs/expected outputs plus a behavioural memory stage.
// Latency: one table row per clock; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_stack_op_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        int_req;
  logic [15:0] mem_data;
  logic        op_ready, stall;
  logic        memory_read, memory_write, memory_push, memory_pop;
  logic [1:0]  memory_write_src_select, memory_address_select;
  logic        interrupt, pc_choose_memory, flags_restore_valid;
  logic [2:0]  flags_restore;

  stack_op_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .int_req(int_req), .mem_data(mem_data), .op_ready(op_ready), .stall(stall),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .memory_write_src_select(memory_write_src_select),
    .memory_address_select(memory_address_select),
    .interrupt(interrupt), .pc_choose_memory(pc_choose_memory),
    .flags_restore_valid(flags_restore_valid), .flags_restore(flags_restore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory stage: register-file sources, a stack, and the popped-PC shift register.
  localparam logic [31:0] PC_VAL  = 32'h0001_0023;
  localparam logic [15:0] REG_VAL = 16'hBEEF;
  localparam logic [15:0] FL_VAL  = 16'h0005;

  logic [15:0] stk [0:31];
  logic [4:0]  sp = 5'd0;
  logic [31:0] shift_pc = 32'h0;
  logic [15:0] wdata;

  always_comb begin
    case (memory_write_src_select)
      2'b00:   wdata = FL_VAL;
      2'b01:   wdata = PC_VAL[31:16];
      2'b10:   wdata = PC_VAL[15:0];
      default: wdata = REG_VAL;
    endcase
  end

  assign mem_data = (sp != 5'd0) ? stk[sp - 5'd1] : 16'h0;

  always @(posedge clk) begin
    if (memory_push) begin
      stk[sp] <= wdata;
      sp      <= sp + 5'd1;
    end else if (memory_pop) begin
      sp       <= sp - 5'd1;
      shift_pc <= {mem_data, shift_pc[31:16]};
    end
  end

  // Per-state output patterns: {read, write, push, pop, src[1:0], addr[1:0], interrupt, pc_mem, flags_vld}
  localparam logic [10:0] O_IDLE  = 11'b0000_00_00_000;
  localparam logic [10:0] O_PREG  = 11'b0110_11_10_000;
  localparam logic [10:0] O_PCH   = 11'b0110_01_10_000;
  localparam logic [10:0] O_PCL   = 11'b0110_10_10_000;
  localparam logic [10:0] O_PFL   = 11'b0110_00_10_000;
  localparam logic [10:0] O_POP   = 11'b1001_00_10_000;
  localparam logic [10:0] O_RJMP  = 11'b0000_00_00_010;
  localparam logic [10:0] O_IJMP  = 11'b0000_00_00_100;
  localparam logic [10:0] O_RTIFL = 11'b1001_00_10_011;

  typedef struct {
    logic        rst;
    logic        ov;
    logic [2:0]  oc;
    logic        ir;
    logic        rdy;
    logic        stl;
    logic [10:0] o;
    int          chk;  // 0 none, 1 popped PC, 2 popped PC and restored flags
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic rst, input logic ov, input logic [2:0] oc, input logic ir,
                     input logic rdy, input logic stl, input logic [10:0] o, input int chk);
    vec_t v;
    v.rst = rst; v.ov = ov; v.oc = oc; v.ir = ir;
    v.rdy = rdy; v.stl = stl; v.o = o; v.chk = chk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  initial begin
    logic [12:0] got, want;

    reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; int_req = 1'b0;

    //   rst ov  oc   ir  rdy stl pattern  chk
    add(1, 0, 3'd0, 0, 1, 0, O_IDLE, 0);   // 0  reset state
    add(0, 1, 3'd1, 0, 1, 0, O_IDLE, 0);   // 1  accept PUSH, no stall
    add(0, 0, 3'd0, 0, 1, 0, O_PREG, 0);   // 2  push register
    add(0, 0, 3'd0, 0, 1, 0, O_IDLE, 0);   // 3  back to IDLE
    add(0, 1, 3'd3, 0, 1, 1, O_IDLE, 0);   // 4  accept CALL, stall
    add(0, 0, 3'd0, 0, 0, 1, O_PCH,  0);   // 5  CALL_HI
    add(0, 1, 3'd4, 0, 1, 1, O_PCL,  0);   // 6  CALL_LO, RET accepted back-to-back
    add(0, 0, 3'd0, 1, 0, 1, O_POP,  0);   // 7  RET_LO, int_req pulse
    add(0, 0, 3'd0, 0, 0, 1, O_POP,  0);   // 8  RET_HI
    add(0, 1, 3'd1, 0, 1, 1, O_RJMP, 1);   // 9  RET_JMP, PUSH refused, interrupt taken
    add(0, 1, 3'd1, 0, 0, 1, O_PFL,  0);   // 10 INT_FL
    add(0, 0, 3'd0, 0, 0, 1, O_PCH,  0);   // 11 INT_HI
    add(0, 0, 3'd0, 0, 0, 1, O_PCL,  0);   // 12 INT_LO
    add(0, 1, 3'd1, 0, 1, 0, O_IJMP, 0);   // 13 INT_JMP, PUSH accepted (pending cleared)
    add(0, 1, 3'd5, 0, 1, 1, O_PREG, 0);   // 14 PUSH, INT instruction accepted
    add(0, 0, 3'd0, 0, 0, 1, O_PFL,  0);   // 15
    add(0, 0, 3'd0, 0, 0, 1, O_PCH,  0);   // 16
    add(0, 0, 3'd0, 0, 0, 1, O_PCL,  0);   // 17
    add(0, 0, 3'd0, 0, 1, 0, O_IJMP, 0);   // 18
    add(0, 1, 3'd6, 1, 1, 1, O_IDLE, 0);   // 19 RTI accepted with simultaneous int_req
    add(0, 0, 3'd0, 0, 0, 1, O_POP,  0);   // 20 RTI_LO
    add(0, 0, 3'd0, 0, 0, 1, O_POP,  0);   // 21 RTI_HI
    add(0, 1, 3'd1, 0, 1, 1, O_RTIFL, 2);  // 22 RTI_FL, latched interrupt taken
    add(0, 0, 3'd0, 1, 0, 1, O_PFL,  0);   // 23 INT_FL, new interrupt latched
    add(1, 0, 3'd0, 0, 0, 1, O_PCH,  0);   // 24 reset in INT_HI
    add(0, 0, 3'd0, 0, 1, 0, O_IDLE, 0);   // 25 aborted, IDLE
    add(0, 1, 3'd1, 0, 1, 0, O_IDLE, 0);   // 26 PUSH accepted: reset dropped the pending int
    add(0, 1, 3'd2, 0, 1, 0, O_PREG, 0);   // 27 POP accepted back-to-back
    add(0, 1, 3'd7, 0, 1, 0, O_POP,  0);   // 28 code 7 ignored
    add(0, 1, 3'd0, 0, 1, 0, O_IDLE, 0);   // 29 NONE ignored
    add(0, 0, 3'd0, 0, 1, 0, O_IDLE, 0);   // 30

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset    = vecs[i].rst;
      op_valid = vecs[i].ov;
      op_code  = vecs[i].oc;
      int_req  = vecs[i].ir;
      @(negedge clk);
      got  = {op_ready, stall, memory_read, memory_write, memory_push, memory_pop,
              memory_write_src_select, memory_address_select,
              interrupt, pc_choose_memory, flags_restore_valid};
      want = {vecs[i].rdy, vecs[i].stl, vecs[i].o};
      check($sformatf("row%0d_outputs", i), {19'h0, got}, {19'h0, want});
      if (vecs[i].chk >= 1)
        check($sformatf("row%0d_final_pc", i), shift_pc, PC_VAL);
      if (vecs[i].chk == 2)
        check($sformatf("row%0d_flags_restore", i), {29'h0, flags_restore}, 32'h5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
